sram_dp_traffic_gen: RTL and testbench

SRAM_DP_TRAFFIC_GEN -- requirements
Module: sram_dp_traffic_gen

---
 rtl/sram_dp_tg_pkg.sv | 25 ++
 rtl/sram_dp_tg_checker.sv | 13 +
 rtl/sram_dp_traffic_gen.sv | 207 ++++++++++++++++++++
 tb/tb_sram_dp_traffic_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_dp_tg_pkg.sv
// Shared SRAM geometry defaults and the traffic-generator package (FSM states, run modes).
// The guarded defines are the sram_dp_hde_params header content shared by the SRAM slice.
`ifndef SRAM_DP_HDE_PARAMS
`define SRAM_DP_HDE_PARAMS
`define ADDR_WIDTH 4
`define BITS 8
`endif

package sram_dp_tg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tg_state_t;

  typedef enum logic [1:0] {
    MODE_FILL     = 2'd0,
    MODE_DUAL_RD  = 2'd1,
    MODE_WR_RD    = 2'd2,
    MODE_BASELINE = 2'd3
  } tg_mode_t;

endpackage

// File: rtl/sram_dp_tg_checker.sv
// Read-data checker: flags a mismatch between returned Q and the expected word.
module sram_dp_tg_checker #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] exp_data,
  input  logic [BITS-1:0] q,
  input  logic            valid,
  output logic            mismatch
);

  assign mismatch = valid && (q != exp_data);

endmodule

// File: rtl/sram_dp_traffic_gen.sv
// Dual-port SRAM traffic generator: fill, dual read-check, write/read-behind and idle baseline runs.
// All SRAM-facing outputs are registered; read data is checked one cycle after each read.
`ifndef SRAM_DP_HDE_PARAMS
`define SRAM_DP_HDE_PARAMS
`define ADDR_WIDTH 4
`define BITS 8
`endif

module sram_dp_traffic_gen
  import sram_dp_tg_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int BITS       = `BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [15:0]           num_ops,
  input  logic [BITS-1:0]       pattern,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic                  CENA,
  output logic                  CENB,
  output logic                  WENA,
  output logic                  WENB,
  output logic [ADDR_WIDTH-1:0] AA,
  output logic [ADDR_WIDTH-1:0] AB,
  output logic [BITS-1:0]       DA,
  output logic [BITS-1:0]       DB,
  input  logic [BITS-1:0]       QA,
  input  logic [BITS-1:0]       QB
);

  // pattern XOR the address replicated across the data width
  function automatic logic [BITS-1:0] data_of(input logic [BITS-1:0] p,
                                              input logic [ADDR_WIDTH-1:0] a);
    logic [BITS-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < BITS; b++) r[b] = p[b] ^ a[b % ADDR_WIDTH];
    return r;
  endfunction

  tg_state_t             state, state_n;
  tg_mode_t              mode_r, mode_n;
  logic [15:0]           nops_r, nops_n;
  logic [15:0]           op, op_n;
  logic [BITS-1:0]       pat_r, pat_n;
  logic                  issue, clr_err;
  logic [ADDR_WIDTH-1:0] a_idx;

  logic                  cena_n, cenb_n, wena_n, wenb_n;
  logic [ADDR_WIDTH-1:0] aa_n, ab_n;
  logic [BITS-1:0]       da_n, db_n;

  logic                  vld_a, vld_b;
  logic [BITS-1:0]       exp_a, exp_b;
  logic                  mm_a, mm_b;
  logic [16:0]           err_sum;
  logic [15:0]           err_nxt;

  always_comb begin
    state_n = state;
    mode_n  = mode_r;
    nops_n  = nops_r;
    pat_n   = pat_r;
    op_n    = op;
    issue   = 1'b0;
    clr_err = 1'b0;
    cena_n  = 1'b1;
    cenb_n  = 1'b1;
    wena_n  = 1'b1;
    wenb_n  = 1'b1;
    aa_n    = '0;
    ab_n    = '0;
    da_n    = '0;
    db_n    = '0;
    a_idx   = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          mode_n  = tg_mode_t'(mode);
          nops_n  = num_ops;
          pat_n   = pattern;
          op_n    = '0;
          clr_err = 1'b1;
          // a zero-length run still spends one access-free cycle before done
          if (num_ops == 16'd0) begin
            state_n = ST_DRAIN;
          end else begin
            state_n = ST_RUN;
            issue   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (op == nops_r - 16'd1) begin
          state_n = ST_DRAIN;
        end else begin
          op_n  = op + 16'd1;
          issue = 1'b1;
        end
      end
      ST_DRAIN: state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    // outputs are computed for the cycle about to start, then registered
    if (issue) begin
      a_idx = op_n[ADDR_WIDTH-1:0];
      case (mode_n)
        MODE_FILL: begin
          cena_n = 1'b0;
          wena_n = 1'b0;
          aa_n   = a_idx;
          da_n   = data_of(pat_n, a_idx);
        end
        MODE_DUAL_RD: begin
          cena_n = 1'b0;
          aa_n   = a_idx;
          cenb_n = 1'b0;
          ab_n   = ~a_idx;
        end
        MODE_WR_RD: begin
          cena_n = 1'b0;
          wena_n = 1'b0;
          aa_n   = a_idx;
          da_n   = data_of(pat_n, a_idx);
          if (op_n != 16'd0) begin
            cenb_n = 1'b0;
            ab_n   = a_idx - ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  sram_dp_tg_checker #(.BITS(BITS)) u_chk_a (
    .exp_data (exp_a),
    .q        (QA),
    .valid    (vld_a),
    .mismatch (mm_a)
  );

  sram_dp_tg_checker #(.BITS(BITS)) u_chk_b (
    .exp_data (exp_b),
    .q        (QB),
    .valid    (vld_b),
    .mismatch (mm_b)
  );

  always_comb begin
    err_sum = {1'b0, err_count} + {16'b0, mm_a} + {16'b0, mm_b};
    err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_r    <= MODE_FILL;
      nops_r    <= '0;
      op        <= '0;
      pat_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      CENA      <= 1'b1;
      CENB      <= 1'b1;
      WENA      <= 1'b1;
      WENB      <= 1'b1;
      AA        <= '0;
      AB        <= '0;
      DA        <= '0;
      DB        <= '0;
      vld_a     <= 1'b0;
      vld_b     <= 1'b0;
      exp_a     <= '0;
      exp_b     <= '0;
    end else begin
      state     <= state_n;
      mode_r    <= mode_n;
      nops_r    <= nops_n;
      op        <= op_n;
      pat_r     <= pat_n;
      busy      <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      done      <= (state_n == ST_DONE);
      err_count <= clr_err ? '0 : err_nxt;
      CENA      <= cena_n;
      CENB      <= cenb_n;
      WENA      <= wena_n;
      WENB      <= wenb_n;
      AA        <= aa_n;
      AB        <= ab_n;
      DA        <= da_n;
      DB        <= db_n;
      vld_a     <= ~CENA & WENA;
      vld_b     <= ~CENB & WENB;
      exp_a     <= data_of(pat_r, AA);
      exp_b     <= data_of(pat_r, AB);
    end
  end

endmodule

// File: tb/tb_sram_dp_traffic_gen.sv
// Directed bench for sram_dp_traffic_gen with a behavioural dual-port SRAM.
module tb_sram_dp_traffic_gen;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [1:0]    mode;
  logic [15:0]   num_ops;
  logic [DW-1:0] pattern;
  logic          busy, done;
  logic [15:0]   err_count;
  logic          CENA, CENB, WENA, WENB;
  logic [AW-1:0] AA, AB;
  logic [DW-1:0] DA, DB, QA, QB;

  logic          init_mem, flip2, corrupt;
  logic [DW-1:0] mem [16];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_dp_traffic_gen #(.ADDR_WIDTH(AW), .BITS(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_ops(num_ops),
    .pattern(pattern), .busy(busy), .done(done), .err_count(err_count),
    .CENA(CENA), .CENB(CENB), .WENA(WENA), .WENB(WENB),
    .AA(AA), .AB(AB), .DA(DA), .DB(DB), .QA(QA), .QB(QB)
  );

  // behavioural SRAM, preloaded with pattern A5 data for every address
  always @(posedge clk) begin
    if (init_mem) begin
      for (int a = 0; a < 16; a++) mem[a] <= 8'hA5 ^ {a[3:0], a[3:0]};
    end else if (flip2) begin
      mem[2] <= mem[2] ^ 8'h01;
    end else begin
      if (!CENA) begin
        if (!WENA) mem[AA] <= DA;
        else       QA <= corrupt ? ~mem[AA] : mem[AA];
      end
      if (!CENB) begin
        if (!WENB) mem[AB] <= DB;
        else       QB <= corrupt ? ~mem[AB] : mem[AB];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [15:0] n, input logic [DW-1:0] p);
    mode = m; num_ops = n; pattern = p; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int c;
    c = 0;
    while (!done && c < budget) begin
      tick();
      c++;
    end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  logic [7:0] fill_d [4] = '{8'hA5, 8'hB4, 8'h87, 8'h96};
  logic [3:0] desc_a [4] = '{4'hF, 4'hE, 4'hD, 4'hC};
  logic [7:0] wr2_d  [3] = '{8'h3C, 8'h2D, 8'h1E};

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; num_ops = '0; pattern = '0;
    init_mem = 1'b1; flip2 = 1'b0; corrupt = 1'b0; QA = '0; QB = '0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    init_mem = 1'b0;
    chk("rst_cena", CENA, 1); chk("rst_cenb", CENB, 1);
    chk("rst_wena", WENA, 1); chk("rst_wenb", WENB, 1);
    chk("rst_aa", AA, 0); chk("rst_ab", AB, 0);
    chk("rst_da", DA, 0); chk("rst_db", DB, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err_count, 0);
    rst = 1'b0;
    tick();

    // mode 0 fill, 4 ops
    launch(2'd0, 16'd4, 8'hA5);
    for (int k = 0; k < 4; k++) begin
      chk("fill_cena", CENA, 0); chk("fill_wena", WENA, 0);
      chk("fill_aa", AA, k); chk("fill_da", DA, fill_d[k]);
      chk("fill_cenb", CENB, 1); chk("fill_busy", busy, 1); chk("fill_done", done, 0);
      tick();
    end
    chk("fill_drain_cena", CENA, 1); chk("fill_drain_done", done, 0);
    tick();
    chk("fill_done6", done, 1); chk("fill_busy_off", busy, 0); chk("fill_err", err_count, 0);
    tick();
    chk("fill_done_pulse", done, 0);

    // mode 1 dual read-check
    launch(2'd1, 16'd4, 8'hA5);
    for (int k = 0; k < 4; k++) begin
      chk("dual_cena", CENA, 0); chk("dual_wena", WENA, 1); chk("dual_aa", AA, k);
      chk("dual_cenb", CENB, 0); chk("dual_wenb", WENB, 1); chk("dual_ab", AB, desc_a[k]);
      tick();
    end
    chk("dual_drain_cena", CENA, 1); chk("dual_drain_cenb", CENB, 1);
    tick();
    chk("dual_done", done, 1); chk("dual_err", err_count, 0);
    tick();

    // one corrupted word
    flip2 = 1'b1; tick(); flip2 = 1'b0;
    launch(2'd1, 16'd4, 8'hA5);
    wait_done(20, "flip_timeout");
    chk("flip_err", err_count, 1);
    tick();
    flip2 = 1'b1; tick(); flip2 = 1'b0;

    // mode 2 write-A / read-behind-B
    launch(2'd2, 16'd3, 8'h3C);
    for (int k = 0; k < 3; k++) begin
      chk("wr2_cena", CENA, 0); chk("wr2_wena", WENA, 0);
      chk("wr2_aa", AA, k); chk("wr2_da", DA, wr2_d[k]);
      chk("wr2_cenb", CENB, (k == 0) ? 1 : 0);
      if (k != 0) begin
        chk("wr2_wenb", WENB, 1); chk("wr2_ab", AB, k - 1);
      end
      tick();
    end
    chk("wr2_drain_cenb", CENB, 1);
    tick();
    chk("wr2_done", done, 1); chk("wr2_err", err_count, 0);
    tick();

    // reset in the third RUN cycle of a fill
    launch(2'd0, 16'd8, 8'hA5);
    tick(); tick();
    chk("abort_pre_cena", CENA, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_cena", CENA, 1); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("abort_no_done", done, 0); chk("abort_no_access", CENA, 1);
    end

    // zero-length run
    launch(2'd1, 16'd0, 8'hA5);
    chk("zero_cena1", CENA, 1); chk("zero_cenb1", CENB, 1); chk("zero_done1", done, 0);
    tick();
    chk("zero_cena2", CENA, 1); chk("zero_done2", done, 1);
    tick();
    chk("zero_pulse_end", done, 0);
    tick();

    // baseline run with a start attempt while busy
    launch(2'd3, 16'd5, 8'hA5);
    for (int c = 1; c <= 7; c++) begin
      chk("base_cena", CENA, 1); chk("base_cenb", CENB, 1);
      chk("base_done", done, (c == 7) ? 1 : 0);
      chk("base_busy", busy, (c <= 6) ? 1 : 0);
      if (c == 2) begin
        mode = 2'd0; num_ops = 16'd2; start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("base_after_busy", busy, 0); chk("base_after_cena", CENA, 1);
    tick();
    chk("base_after2_busy", busy, 0);

    // saturation with both ports always wrong
    corrupt = 1'b1;
    launch(2'd1, 16'hFFFF, 8'hA5);
    wait_done(70000, "sat_timeout");
    chk("sat_err", err_count, 16'hFFFF);
    corrupt = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
